// File: rtl/mouse_packet_tracker_pkg.sv
// Shared types and constants for the PS/2 mouse packet tracker:
// packet-assembly states, header bit positions and default screen limits.
package mouse_pkg;

    typedef enum logic [1:0] {
        B0,
        B1,
        B2,
        UPD
    } state_t;

    localparam int unsigned BTN_L = 0;
    localparam int unsigned BTN_R = 1;
    localparam int unsigned BTN_M = 2;
    localparam int unsigned SYNC  = 3;
    localparam int unsigned XS    = 4;
    localparam int unsigned YS    = 5;
    localparam int unsigned XO    = 6;
    localparam int unsigned YO    = 7;

    localparam int unsigned X_MAX_DEF  = 639;
    localparam int unsigned Y_MAX_DEF  = 479;
    localparam int unsigned X_INIT_DEF = 320;
    localparam int unsigned Y_INIT_DEF = 240;

    // 9-bit signed delta from header sign/overflow bits; overflow reports zero motion.
    function automatic logic signed [8:0] decode_delta(
        input logic [7:0]  hdr,
        input logic [7:0]  lo,
        input int unsigned sign_bit,
        input int unsigned ovf_bit
    );
        if (hdr[ovf_bit])
            return '0;
        return signed'({hdr[sign_bit], lo});
    endfunction

endpackage

// File: rtl/mouse_packet_tracker_if.sv
// Byte stream from the PS/2 byte receiver into the packet tracker.
interface mouse_packet_tracker_if;

    logic [7:0] rx_data;
    logic       rx_valid;

    modport master (
        output rx_data,
        output rx_valid
    );

    modport slave (
        input rx_data,
        input rx_valid
    );

endinterface

// File: rtl/mouse_packet_tracker_clamp.sv
// One cursor axis: applies a signed delta (added or subtracted) to a position
// and saturates the result to [0, i_max].
module mouse_axis_clamp (
    input  logic [9:0]        i_pos,
    input  logic signed [8:0] i_delta,
    input  logic              i_sub,
    input  logic [9:0]        i_max,
    output logic [9:0]        o_pos
);

    logic signed [11:0] w_pos;
    logic signed [11:0] w_delta;
    logic signed [11:0] w_max;
    logic signed [11:0] w_sum;

    always_comb begin
        w_pos   = signed'({2'b00, i_pos});
        w_delta = signed'({{3{i_delta[8]}}, i_delta});
        w_max   = signed'({2'b00, i_max});
        w_sum   = i_sub ? (w_pos - w_delta) : (w_pos + w_delta);
        if (w_sum[11])
            o_pos = '0;
        else if (w_sum > w_max)
            o_pos = i_max;
        else
            o_pos = w_sum[9:0];
    end

endmodule

// File: rtl/mouse_packet_tracker.sv
// Assembles 3-byte PS/2 mouse packets and accumulates their deltas into a
// clamped absolute cursor position with button levels and event strobes.
module mouse_packet_tracker
    import mouse_pkg::*;
#(
    parameter int unsigned X_MAX       = X_MAX_DEF,
    parameter int unsigned Y_MAX       = Y_MAX_DEF,
    parameter int unsigned X_INIT      = X_INIT_DEF,
    parameter int unsigned Y_INIT      = Y_INIT_DEF,
    parameter int unsigned TIMEOUT_CYC = 2000000
) (
    input  logic                    clk,
    input  logic                    rst,
    mouse_packet_tracker_if.slave   rx,
    output logic [9:0]              MOUSE_X_POS,
    output logic [9:0]              MOUSE_Y_POS,
    output logic                    MOUSE_LEFT,
    output logic                    MOUSE_MIDDLE,
    output logic                    MOUSE_RIGHT,
    output logic                    new_event,
    output logic                    sync_err
);

    localparam int unsigned     CNT_W    = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [9:0]      W_X_MAX  = 10'(X_MAX);
    localparam logic [9:0]      W_Y_MAX  = 10'(Y_MAX);

    state_t           r_state;
    logic [7:0]       r_hdr;
    logic [7:0]       r_dx_lo;
    logic [7:0]       r_dy_lo;
    logic [CNT_W-1:0] r_cnt;
    logic [9:0]       r_x_pos;
    logic [9:0]       r_y_pos;
    logic             r_left;
    logic             r_middle;
    logic             r_right;
    logic             r_new_event;
    logic             r_sync_err;

    logic signed [8:0] w_dx;
    logic signed [8:0] w_dy;
    logic [9:0]        w_x_next;
    logic [9:0]        w_y_next;

    always_comb begin
        w_dx = decode_delta(r_hdr, r_dx_lo, XS, XO);
        w_dy = decode_delta(r_hdr, r_dy_lo, YS, YO);
    end

    mouse_axis_clamp u_clamp_x (
        .i_pos   (r_x_pos),
        .i_delta (w_dx),
        .i_sub   (1'b0),
        .i_max   (W_X_MAX),
        .o_pos   (w_x_next)
    );

    // PS/2 reports Y up-positive; screen Y grows downward.
    mouse_axis_clamp u_clamp_y (
        .i_pos   (r_y_pos),
        .i_delta (w_dy),
        .i_sub   (1'b1),
        .i_max   (W_Y_MAX),
        .o_pos   (w_y_next)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= B0;
            r_hdr       <= '0;
            r_dx_lo     <= '0;
            r_dy_lo     <= '0;
            r_cnt       <= '0;
            r_x_pos     <= 10'(X_INIT);
            r_y_pos     <= 10'(Y_INIT);
            r_left      <= 1'b0;
            r_middle    <= 1'b0;
            r_right     <= 1'b0;
            r_new_event <= 1'b0;
            r_sync_err  <= 1'b0;
        end else begin
            r_new_event <= 1'b0;
            r_sync_err  <= 1'b0;
            case (r_state)
                B0, UPD: begin
                    r_cnt <= '0;
                    if (r_state == UPD) begin
                        r_x_pos     <= w_x_next;
                        r_y_pos     <= w_y_next;
                        r_left      <= r_hdr[BTN_L];
                        r_right     <= r_hdr[BTN_R];
                        r_middle    <= r_hdr[BTN_M];
                        r_new_event <= 1'b1;
                    end
                    // A byte landing in the commit cycle is already a header candidate.
                    r_state <= B0;
                    if (rx.rx_valid) begin
                        if (rx.rx_data[SYNC]) begin
                            r_hdr   <= rx.rx_data;
                            r_state <= B1;
                        end else begin
                            r_sync_err <= 1'b1;
                        end
                    end
                end
                B1, B2: begin
                    if (rx.rx_valid) begin
                        r_cnt <= '0;
                        if (r_state == B1) begin
                            r_dx_lo <= rx.rx_data;
                            r_state <= B2;
                        end else begin
                            r_dy_lo <= rx.rx_data;
                            r_state <= UPD;
                        end
                    end else if (r_cnt == CNT_LAST) begin
                        r_cnt      <= '0;
                        r_sync_err <= 1'b1;
                        r_state    <= B0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= B0;
            endcase
        end
    end

    assign MOUSE_X_POS  = r_x_pos;
    assign MOUSE_Y_POS  = r_y_pos;
    assign MOUSE_LEFT   = r_left;
    assign MOUSE_MIDDLE = r_middle;
    assign MOUSE_RIGHT  = r_right;
    assign new_event    = r_new_event;
    assign sync_err     = r_sync_err;

endmodule

// File: tb/tb_mouse_packet_tracker.sv
// Randomized and directed bench for mouse_packet_tracker against a
// transaction-level packet model with expected event timestamps.
module tb_mouse_packet_tracker;

    localparam int T      = 40;
    localparam int XMAX   = 639;
    localparam int YMAX   = 479;
    localparam int XINIT  = 320;
    localparam int YINIT  = 240;

    typedef struct {
        int kind;   // 1 = new_event, 0 = sync_err
        int cyc;
        int x;
        int y;
        int btn;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mouse_packet_tracker_if u_if ();

    logic [9:0] x_pos;
    logic [9:0] y_pos;
    logic       left_b;
    logic       middle_b;
    logic       right_b;
    logic       new_event;
    logic       sync_err;

    mouse_packet_tracker #(
        .X_MAX       (XMAX),
        .Y_MAX       (YMAX),
        .X_INIT      (XINIT),
        .Y_INIT      (YINIT),
        .TIMEOUT_CYC (T)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .rx           (u_if),
        .MOUSE_X_POS  (x_pos),
        .MOUSE_Y_POS  (y_pos),
        .MOUSE_LEFT   (left_b),
        .MOUSE_MIDDLE (middle_b),
        .MOUSE_RIGHT  (right_b),
        .new_event    (new_event),
        .sync_err     (sync_err)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    ev_t exp_q[$];
    ev_t obs_q[$];

    // Reference model state
    int         m_x, m_y, m_btn, m_idx, m_last_e;
    logic [7:0] m_hdr, m_dx;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic ev_t mk_ev(int kind, int c, int x, int y, int btn);
        ev_t e;
        e.kind = kind; e.cyc = c; e.x = x; e.y = y; e.btn = btn;
        return e;
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            if (new_event)
                obs_q.push_back(mk_ev(1, cyc, int'(x_pos), int'(y_pos),
                                      int'({middle_b, right_b, left_b})));
            if (sync_err)
                obs_q.push_back(mk_ev(0, cyc, 0, 0, 0));
        end
    end

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic int clampi(int v, int hi);
        if (v < 0) return 0;
        if (v > hi) return hi;
        return v;
    endfunction

    function automatic int delta9(logic sgn, logic ovf, logic [7:0] lo);
        if (ovf) return 0;
        return sgn ? int'(lo) - 256 : int'(lo);
    endfunction

    task automatic model_reset();
        m_x = XINIT; m_y = YINIT; m_btn = 0; m_idx = 0; m_last_e = 0;
        exp_q.delete();
        obs_q.delete();
    endtask

    // e = clock edge at which the DUT samples this byte
    task automatic model_byte(input logic [7:0] b, input int e);
        int dy;
        if (m_idx > 0 && (e - m_last_e - 1) >= T) begin
            exp_q.push_back(mk_ev(0, m_last_e + T, 0, 0, 0));
            m_idx = 0;
        end
        case (m_idx)
            0: begin
                if (b[3]) begin m_hdr = b; m_idx = 1; end
                else exp_q.push_back(mk_ev(0, e, 0, 0, 0));
            end
            1: begin m_dx = b; m_idx = 2; end
            default: begin
                dy    = delta9(m_hdr[5], m_hdr[7], b);
                m_x   = clampi(m_x + delta9(m_hdr[4], m_hdr[6], m_dx), XMAX);
                m_y   = clampi(m_y - dy, YMAX);
                m_btn = int'(m_hdr[2:0]);
                exp_q.push_back(mk_ev(1, e + 1, m_x, m_y, m_btn));
                m_idx = 0;
            end
        endcase
        m_last_e = e;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        idle(gap);
        u_if.rx_data  = b;
        u_if.rx_valid = 1'b1;
        model_byte(b, cyc + 1);
        @(posedge clk);
        #1;
        u_if.rx_valid = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] h, input logic [7:0] dx, input logic [7:0] dy);
        send_byte(h, 0);
        send_byte(dx, 0);
        send_byte(dy, 0);
    endtask

    task automatic finish_phase(input string name);
        int n;
        idle(T + 5);
        if (m_idx > 0 && (cyc - m_last_e) >= T) begin
            exp_q.push_back(mk_ev(0, m_last_e + T, 0, 0, 0));
            m_idx = 0;
        end
        check_val({name, "/n_events"}, obs_q.size(), exp_q.size());
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check_val($sformatf("%s/ev%0d_kind", name, i), obs_q[i].kind, exp_q[i].kind);
            check_val($sformatf("%s/ev%0d_cyc", name, i), obs_q[i].cyc, exp_q[i].cyc);
            if (exp_q[i].kind == 1) begin
                check_val($sformatf("%s/ev%0d_x", name, i), obs_q[i].x, exp_q[i].x);
                check_val($sformatf("%s/ev%0d_y", name, i), obs_q[i].y, exp_q[i].y);
                check_val($sformatf("%s/ev%0d_btn", name, i), obs_q[i].btn, exp_q[i].btn);
            end
        end
        check_val({name, "/hold_x"}, int'(x_pos), m_x);
        check_val({name, "/hold_y"}, int'(y_pos), m_y);
        check_val({name, "/hold_btn"}, int'({middle_b, right_b, left_b}), m_btn);
        exp_q.delete();
        obs_q.delete();
    endtask

    task automatic do_reset(input string name);
        rst = 1'b1;
        idle(3);
        model_reset();
        rst = 1'b0;
        check_val({name, "/rst_x"}, int'(x_pos), XINIT);
        check_val({name, "/rst_y"}, int'(y_pos), YINIT);
        check_val({name, "/rst_btn"}, int'({middle_b, right_b, left_b}), 0);
        check_val({name, "/rst_new_event"}, int'(new_event), 0);
        check_val({name, "/rst_sync_err"}, int'(sync_err), 0);
    endtask

    function automatic int rgap();
        int r;
        r = $urandom_range(0, 99);
        if (r < 80) return $urandom_range(0, 3);
        if (r < 88) return T - 1;
        if (r < 95) return T;
        return T + $urandom_range(1, 5);
    endfunction

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int x_before;
        logic [7:0] h;
        u_if.rx_data  = '0;
        u_if.rx_valid = 1'b0;
        idle(2);
        do_reset("init");

        send_pkt(8'h09, 8'h05, 8'h03);
        finish_phase("basic");
        check_val("basic/x", int'(x_pos), 325);
        check_val("basic/y", int'(y_pos), 237);
        check_val("basic/left", int'(left_b), 1);

        do_reset("neg");
        send_pkt(8'h18, 8'hF6, 8'h00);
        finish_phase("neg");
        check_val("neg/x", int'(x_pos), 310);
        check_val("neg/y", int'(y_pos), 240);
        check_val("neg/left", int'(left_b), 0);

        do_reset("clamp");
        send_pkt(8'h08, 8'hFF, 8'h00);
        send_pkt(8'h08, 8'h3C, 8'h00);
        finish_phase("clamp_pre");
        check_val("clamp/x635", int'(x_pos), 635);
        send_pkt(8'h08, 8'h14, 8'h00);
        send_pkt(8'h08, 8'h00, 8'hEE);
        finish_phase("clamp_x");
        check_val("clamp/x639", int'(x_pos), 639);
        check_val("clamp/y2", int'(y_pos), 2);
        send_pkt(8'h08, 8'h00, 8'h05);
        finish_phase("clamp_y");
        check_val("clamp/y0", int'(y_pos), 0);

        do_reset("misalign");
        send_byte(8'h00, 0);
        send_pkt(8'h09, 8'h05, 8'h03);
        finish_phase("misalign");
        check_val("misalign/x", int'(x_pos), 325);

        send_byte(8'h08, 0);
        send_byte(8'h10, 0);
        finish_phase("timeout");
        send_pkt(8'h09, 8'h01, 8'h01);
        send_byte(8'h08, 2);
        send_byte(8'h02, T - 1);
        send_byte(8'h02, T - 1);
        send_byte(8'h0A, 1);
        send_byte(8'h07, T);
        send_byte(8'h0C, 0);
        send_byte(8'h01, 0);
        send_byte(8'h01, 0);
        finish_phase("timeout_edge");

        x_before = m_x;
        send_pkt(8'h48, 8'h7F, 8'h00);
        send_pkt(8'h09, 8'h01, 8'h01);
        send_byte(8'h00, 0);
        finish_phase("ovf_upd");
        check_val("ovf/x", int'(x_pos), x_before + 1);

        send_byte(8'h08, 0);
        send_byte(8'h10, 0);
        do_reset("midpkt");
        send_pkt(8'h0A, 8'h02, 8'h00);
        finish_phase("midpkt");

        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 9) < 7) begin
                h = 8'($urandom);
                h[3] = 1'b1;
                if ($urandom_range(0, 3) != 0) h[7:6] = 2'b00;
                send_byte(h, rgap());
                send_byte(8'($urandom), rgap());
                send_byte(8'($urandom), rgap());
            end else begin
                send_byte(8'($urandom), rgap());
            end
            if (k % 25 == 24) finish_phase($sformatf("rand%0d", k));
        end
        finish_phase("rand_end");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
